// File: rtl/lsu_mem_stage.sv
// Load/store unit between the execute stage and data memory: one access in flight, byte-lane
// alignment and load extension. Define LSU_TIMEOUT_EN to enable the load-response watchdog.
module lsu_mem_stage #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_out,
  input  logic [31:0] store_data,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic [31:0] dmem_req_addr,
  output logic [3:0]  dmem_req_we,
  output logic [31:0] dmem_req_wdata,
  input  logic        dmem_resp_valid,
  input  logic [31:0] dmem_resp_data,
  output logic        stall,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        lsu_fault,
  output logic        lsu_timeout
);
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, DONE} state_t;
  state_t r_state, w_state_nxt;

  logic [29:0] r_waddr;
  logic [1:0]  r_off;
  logic [2:0]  r_funct3;
  logic [3:0]  r_mask;
  logic [31:0] r_wdata;
  logic        r_is_load;
  logic [31:0] r_load_data;

  logic w_is_ld, w_is_st, w_ls, w_legal;
  logic w_accept, w_fault, w_stall, w_wd_expire;

  function automatic logic f_legal(input logic is_load, input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = ~off[0];
      3'b010:  ok = (off == 2'b00);
      3'b100:  ok = is_load;
      3'b101:  ok = is_load & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] f_mask(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] m;
    case (sz)
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = 4'b0011 << off;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] f_wdata(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] w;
    case (sz)
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] f_extend(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'h0, b};
      3'b101:  r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign w_is_ld = (opcode == OPC_LOAD);
  assign w_is_st = (opcode == OPC_STORE);
  assign w_ls    = ex_valid & (w_is_ld | w_is_st);
  assign w_legal = f_legal(w_is_ld, funct3, alu_out[1:0]);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_fault     = 1'b0;
    w_stall     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ls) begin
          if (w_legal) begin
            w_accept    = 1'b1;
            w_stall     = 1'b1;
            w_state_nxt = REQ;
          end else begin
            w_fault = 1'b1;
          end
        end
      end
      REQ: begin
        w_stall = 1'b1;
        if (dmem_req_ready) w_state_nxt = r_is_load ? WAIT_RESP : DONE;
      end
      WAIT_RESP: begin
        w_stall = 1'b1;
        if (dmem_resp_valid || w_wd_expire) w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_waddr     <= '0;
      r_off       <= '0;
      r_funct3    <= '0;
      r_mask      <= '0;
      r_wdata     <= '0;
      r_is_load   <= 1'b0;
      r_load_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_waddr   <= alu_out[31:2];
        r_off     <= alu_out[1:0];
        r_funct3  <= funct3;
        r_is_load <= w_is_ld;
        r_mask    <= w_is_ld ? 4'b0000 : f_mask(funct3[1:0], alu_out[1:0]);
        r_wdata   <= w_is_ld ? 32'h0 : f_wdata(funct3[1:0], store_data);
      end
      // A response wins over a watchdog expiry landing in the same cycle
      if (r_state == WAIT_RESP) begin
        if (dmem_resp_valid)  r_load_data <= f_extend(r_funct3, r_off, dmem_resp_data);
        else if (w_wd_expire) r_load_data <= '0;
      end
    end
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_timed_out;

  assign w_wd_expire = (r_state == WAIT_RESP) && !dmem_resp_valid &&
                       (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_timed_out <= 1'b0;
    end else begin
      if (r_state == REQ)            r_cnt <= '0;
      else if (r_state == WAIT_RESP) r_cnt <= r_cnt + 1'b1;
      if (w_accept)         r_timed_out <= 1'b0;
      else if (w_wd_expire) r_timed_out <= 1'b1;
    end
  end

  assign lsu_timeout = (r_state == DONE) && r_timed_out;
`else
  assign w_wd_expire = 1'b0;
  assign lsu_timeout = 1'b0;
`endif

  assign dmem_req_valid = (r_state == REQ);
  assign dmem_req_addr  = {r_waddr, 2'b00};
  assign dmem_req_we    = r_mask;
  assign dmem_req_wdata = r_wdata;
  assign stall          = w_stall & ~reset;
  assign lsu_fault      = w_fault & ~reset;
  assign load_valid     = (r_state == DONE) && r_is_load;
  assign load_data      = r_load_data;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: expected requests/loads queued at issue, compared on output.
`timescale 1ns/1ps
module tb_lsu_mem_stage;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] alu_out;
  logic [31:0] store_data;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic [31:0] dmem_req_addr;
  logic [3:0]  dmem_req_we;
  logic [31:0] dmem_req_wdata;
  logic        dmem_resp_valid;
  logic [31:0] dmem_resp_data;
  logic        stall;
  logic        load_valid;
  logic [31:0] load_data;
  logic        lsu_fault;
  logic        lsu_timeout;

  always #5 clk = ~clk;

  lsu_mem_stage dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .opcode(opcode), .funct3(funct3),
    .alu_out(alu_out), .store_data(store_data), .dmem_req_valid(dmem_req_valid),
    .dmem_req_ready(dmem_req_ready), .dmem_req_addr(dmem_req_addr), .dmem_req_we(dmem_req_we),
    .dmem_req_wdata(dmem_req_wdata), .dmem_resp_valid(dmem_resp_valid),
    .dmem_resp_data(dmem_resp_data), .stall(stall), .load_valid(load_valid),
    .load_data(load_data), .lsu_fault(lsu_fault), .lsu_timeout(lsu_timeout)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic        is_st;
  } req_t;

  req_t        exp_req_q[$];
  logic [31:0] exp_ld_q[$];
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (dmem_req_valid && dmem_req_ready) begin
        if (exp_req_q.size() == 0) chk("req_unexpected_q", 32'(exp_req_q.size()), 32'd1);
        else begin
          req_t e;
          e = exp_req_q.pop_front();
          chk("req_addr", dmem_req_addr, e.addr);
          chk("req_we", 32'(dmem_req_we), 32'(e.we));
          if (e.is_st) chk("req_wdata", dmem_req_wdata, e.wdata);
        end
      end
      if (load_valid) begin
        if (exp_ld_q.size() == 0) chk("ld_unexpected_q", 32'(exp_ld_q.size()), 32'd1);
        else chk("ld_data", load_data, exp_ld_q.pop_front());
      end
    end
  end

  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input int rdy_dly, input int rsp_dly,
                        input logic [31:0] rsp, input logic [31:0] exp_ld,
                        input logic [3:0] exp_we, input logic [31:0] exp_wd);
    req_t e;
    e.addr = {a[31:2], 2'b00};
    e.we = exp_we;
    e.wdata = exp_wd;
    e.is_st = st;
    exp_req_q.push_back(e);
    if (!st) exp_ld_q.push_back(exp_ld);
    ex_valid = 1'b1;
    opcode = st ? OPC_STORE : OPC_LOAD;
    funct3 = f3;
    alu_out = a;
    store_data = sd;
    dmem_req_ready = (rdy_dly == 0);
    @(negedge clk);
    chk("acc_stall", 32'(stall), 32'd1);
    chk("acc_fault", 32'(lsu_fault), 32'd0);
    chk("acc_rv", 32'(dmem_req_valid), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge clk);
      chk("hold_rv", 32'(dmem_req_valid), 32'd1);
      chk("hold_stall", 32'(stall), 32'd1);
      chk("hold_addr", dmem_req_addr, e.addr);
      chk("hold_we", 32'(dmem_req_we), 32'(exp_we));
      if (st) chk("hold_wdata", dmem_req_wdata, exp_wd);
      @(posedge clk); #1;
      if (i == rdy_dly - 1) dmem_req_ready = 1'b1;
    end
    @(negedge clk);
    chk("hs_rv", 32'(dmem_req_valid), 32'd1);
    chk("hs_stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    dmem_req_ready = 1'b0;
    if (!st) begin
      for (int j = 0; j < rsp_dly; j++) begin
        @(negedge clk);
        chk("wait_stall", 32'(stall), 32'd1);
        chk("wait_rv", 32'(dmem_req_valid), 32'd0);
        chk("wait_to", 32'(lsu_timeout), 32'd0);
        @(posedge clk); #1;
      end
      dmem_resp_valid = 1'b1;
      dmem_resp_data = rsp;
      @(negedge clk);
      chk("resp_stall", 32'(stall), 32'd1);
      chk("resp_lv", 32'(load_valid), 32'd0);
      @(posedge clk); #1;
    end
    // stray response while in DONE must be ignored
    dmem_resp_valid = 1'b1;
    dmem_resp_data = ~rsp;
    @(negedge clk);
    chk("done_stall", 32'(stall), 32'd0);
    chk("done_lv", 32'(load_valid), 32'(!st));
    chk("done_rv", 32'(dmem_req_valid), 32'd0);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    dmem_resp_valid = 1'b0;
    @(negedge clk);
    chk("idle_lv", 32'(load_valid), 32'd0);
    chk("idle_stall", 32'(stall), 32'd0);
    if (!st) chk("ld_hold", load_data, exp_ld);
    @(posedge clk); #1;
  endtask

  task automatic run_bad(input logic st, input logic [2:0] f3, input logic [31:0] a);
    ex_valid = 1'b1;
    opcode = st ? OPC_STORE : OPC_LOAD;
    funct3 = f3;
    alu_out = a;
    store_data = $urandom;
    dmem_req_ready = 1'b1;
    @(negedge clk);
    chk("bad_fault", 32'(lsu_fault), 32'd1);
    chk("bad_stall", 32'(stall), 32'd0);
    chk("bad_rv", 32'(dmem_req_valid), 32'd0);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    @(negedge clk);
    chk("bad_fault_clr", 32'(lsu_fault), 32'd0);
    chk("bad_rv_after", 32'(dmem_req_valid), 32'd0);
    @(posedge clk); #1;
    dmem_req_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        st;
    logic [2:0]  f3;
    logic [1:0]  o;
    logic [31:0] a, sd, rsp, ev, lane, wd;
    logic [3:0]  we;
    int          sel;
    req_t        e6;

    reset = 1'b1;
    ex_valid = 1'b0;
    opcode = '0;
    funct3 = '0;
    alu_out = '0;
    store_data = '0;
    dmem_req_ready = 1'b0;
    dmem_resp_valid = 1'b0;
    dmem_resp_data = '0;
    repeat (3) @(posedge clk);
    #1;
    ex_valid = 1'b1;
    opcode = OPC_LOAD;
    funct3 = 3'b010;
    alu_out = 32'h0000_0010;
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rv", 32'(dmem_req_valid), 32'd0);
    chk("rst_addr", dmem_req_addr, 32'd0);
    chk("rst_we", 32'(dmem_req_we), 32'd0);
    chk("rst_wdata", dmem_req_wdata, 32'd0);
    chk("rst_lv", 32'(load_valid), 32'd0);
    chk("rst_ld", load_data, 32'd0);
    chk("rst_fault", 32'(lsu_fault), 32'd0);
    chk("rst_to", 32'(lsu_timeout), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    ex_valid = 1'b0;
    @(posedge clk); #1;

    run_op(1'b1, 3'b010, 32'h1000_0004, 32'hCAFE_BABE, 0, 0, 32'h0, 32'h0, 4'b1111, 32'hCAFE_BABE);
    run_op(1'b1, 3'b000, 32'h2000_0001, 32'h0000_00A5, 3, 0, 32'h0, 32'h0, 4'b0010, 32'hA5A5_A5A5);
    run_op(1'b0, 3'b000, 32'h3000_0003, 32'h0, 0, 2, 32'h80AA_BBCC, 32'hFFFF_FF80, 4'b0000, 32'h0);
    run_op(1'b0, 3'b100, 32'h3000_0003, 32'h0, 0, 2, 32'h80AA_BBCC, 32'h0000_0080, 4'b0000, 32'h0);
    run_op(1'b0, 3'b001, 32'h3000_0002, 32'h0, 1, 1, 32'h8001_5678, 32'hFFFF_8001, 4'b0000, 32'h0);
    run_op(1'b0, 3'b101, 32'h3000_0002, 32'h0, 0, 0, 32'h8001_5678, 32'h0000_8001, 4'b0000, 32'h0);
    run_op(1'b0, 3'b010, 32'h3000_0000, 32'h0, 2, 2, 32'h8001_5678, 32'h8001_5678, 4'b0000, 32'h0);

    // reset while waiting for a load response
    e6 = '{addr: 32'h3000_0000, we: 4'b0000, wdata: 32'h0, is_st: 1'b0};
    exp_req_q.push_back(e6);
    ex_valid = 1'b1;
    opcode = OPC_LOAD;
    funct3 = 3'b010;
    alu_out = 32'h3000_0000;
    dmem_req_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    dmem_req_ready = 1'b0;
    reset = 1'b1;
    ex_valid = 1'b0;
    @(negedge clk);
    chk("r6_stall_in_rst", 32'(stall), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    dmem_resp_valid = 1'b1;
    dmem_resp_data = 32'h1234_5678;
    @(negedge clk);
    chk("r6_rv", 32'(dmem_req_valid), 32'd0);
    chk("r6_stall", 32'(stall), 32'd0);
    chk("r6_lv", 32'(load_valid), 32'd0);
    chk("r6_ld", load_data, 32'd0);
    chk("r6_addr", dmem_req_addr, 32'd0);
    chk("r6_we", 32'(dmem_req_we), 32'd0);
    chk("r6_wdata", dmem_req_wdata, 32'd0);
    @(posedge clk); #1;
    dmem_resp_valid = 1'b0;
    @(negedge clk);
    chk("r6_lv_after", 32'(load_valid), 32'd0);
    chk("r6_ld_after", load_data, 32'd0);
    @(posedge clk); #1;

    run_bad(1'b0, 3'b010, 32'h3000_0002);
    run_bad(1'b1, 3'b001, 32'h3000_0001);
    run_bad(1'b0, 3'b011, 32'h3000_0000);
    run_bad(1'b1, 3'b100, 32'h3000_0000);

    // non-memory opcode is ignored
    ex_valid = 1'b1;
    opcode = 7'b0110011;
    funct3 = 3'b011;
    alu_out = 32'h0000_0003;
    @(negedge clk);
    chk("alu_op_stall", 32'(stall), 32'd0);
    chk("alu_op_fault", 32'(lsu_fault), 32'd0);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    @(negedge clk);
    chk("alu_op_rv", 32'(dmem_req_valid), 32'd0);
    @(posedge clk); #1;

    for (int k = 0; k < 24; k++) begin
      st = 1'($urandom_range(0, 1));
      if (st) begin
        sel = $urandom_range(0, 2);
        f3 = 3'(sel);
      end else begin
        sel = $urandom_range(0, 4);
        f3 = (sel < 3) ? 3'(sel) : 3'(sel + 1);
      end
      a = $urandom;
      if (f3[1:0] == 2'b01) a[0] = 1'b0;
      if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      sd = $urandom;
      rsp = $urandom;
      o = a[1:0];
      we = 4'b0000;
      wd = 32'h0;
      ev = 32'h0;
      if (st) begin
        case (f3[1:0])
          2'b00:   begin we = 4'(4'd1 << o); wd = {24'h0, sd[7:0]} * 32'h0101_0101; end
          2'b01:   begin we = 4'(4'd3 << o); wd = {16'h0, sd[15:0]} * 32'h0001_0001; end
          default: begin we = 4'b1111; wd = sd; end
        endcase
      end else begin
        lane = rsp >> (8 * o);
        case (f3)
          3'b000:  ev = 32'(signed'(lane[7:0]));
          3'b001:  ev = 32'(signed'(lane[15:0]));
          3'b100:  ev = lane & 32'h0000_00FF;
          3'b101:  ev = lane & 32'h0000_FFFF;
          default: ev = rsp;
        endcase
      end
      run_op(st, f3, a, sd, $urandom_range(0, 2), $urandom_range(0, 2), rsp, ev, we, wd);
    end

`ifdef LSU_TIMEOUT_EN
    begin
      int n;
      e6 = '{addr: 32'h4000_0000, we: 4'b0000, wdata: 32'h0, is_st: 1'b0};
      exp_req_q.push_back(e6);
      exp_ld_q.push_back(32'h0);
      ex_valid = 1'b1;
      opcode = OPC_LOAD;
      funct3 = 3'b010;
      alu_out = 32'h4000_0000;
      dmem_req_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      dmem_req_ready = 1'b0;
      n = 0;
      @(negedge clk);
      while (!lsu_timeout && n < 200) begin
        n++;
        @(negedge clk);
      end
      chk("to_cycles", 32'(n), 32'd64);
      chk("to_lv", 32'(load_valid), 32'd1);
      chk("to_ld", load_data, 32'd0);
      @(posedge clk); #1;
      ex_valid = 1'b0;
      @(negedge clk);
      chk("to_pulse_clr", 32'(lsu_timeout), 32'd0);
      @(posedge clk); #1;
    end
`else
    run_op(1'b0, 3'b010, 32'h5000_0000, 32'h0, 0, 80, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b0000, 32'h0);
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_req_empty", 32'(exp_req_q.size()), 32'd0);
    chk("sb_ld_empty", 32'(exp_ld_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit sitting directly downstream of the execute-stage ALU.
- Consumes the ALU result as the effective address for OPC_LOAD/OPC_STORE instructions.
- Drives a valid/ready request to data memory, collects the load response, and byte-aligns and sign- or zero-extends the result.
- Holds the pipeline via a stall output until the access completes.

Parameters:
TIMEOUT_CYCLES, 64, response watchdog limit in cycles; used only when LSU_TIMEOUT_EN is defined.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
ex_valid  input  1  execute stage holds a valid instruction this cycle
opcode  input  7  instruction opcode; only OPC_LOAD / OPC_STORE act
funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
alu_out  input  32  effective address from ALU Out
store_data  input  32  rs2 value for stores
dmem_req_valid  output  1  memory request valid
dmem_req_ready  input  1  memory accepts request
dmem_req_addr  output  32  word address, bits [1:0] forced 0
dmem_req_we  output  4  byte write mask; 0000 for loads
dmem_req_wdata  output  32  lane-replicated store data
dmem_resp_valid  input  1  load response valid (never returned for stores)
dmem_resp_data  input  32  raw load word
stall  output  1  hold upstream pipeline
load_valid  output  1  one-cycle pulse: load_data valid
load_data  output  32  aligned, extended load result
lsu_fault  output  1  one-cycle pulse: misaligned or illegal funct3
lsu_timeout  output  1  one-cycle pulse: watchdog expired (0 when feature is compiled out)

Behaviour:
- Reset: all outputs 0; FSM goes to IDLE; latched address/data/mask cleared.
- FSM states: IDLE, REQ, WAIT_RESP, DONE.
- IDLE, accept condition: ex_valid=1, opcode is LOAD or STORE, and the access is legal.
  - On accept: latch address, funct3, lane mask, wdata and load/store kind; go to REQ.
  - stall is driven high combinationally in the accept cycle.
- Illegal access means any of:
  - H/HU with alu_out[0]=1;
  - W with alu_out[1:0]!=0;
  - load funct3 in {011, 110, 111};
  - store funct3 other than 000/001/010.
  - On an illegal access: lsu_fault pulses in that same cycle (combinational), no request is issued, state stays IDLE, stall stays 0.
- REQ: dmem_req_valid=1, registered, with a stable payload until dmem_req_ready=1.
  - On handshake: a store goes to DONE; a load goes to WAIT_RESP.
  - stall=1.
  - dmem_resp_valid is ignored in REQ.
- WAIT_RESP: stall=1, dmem_req_valid=0.
  - On dmem_resp_valid: select the lane by addr[1:0], extend per funct3, register into load_data, go to DONE.
- DONE: stall=0.
  - For loads, load_valid=1 for exactly this cycle; load_data holds its value until the next load completes.
  - Inputs in DONE still describe the completed instruction and are ignored.
  - Always DONE -> IDLE.
- Store lane rules, with o = addr[1:0]:
  - SB: mask 0001<<o, wdata = byte replicated 4x.
  - SH: mask 0011<<o, wdata = half replicated 2x.
  - SW: mask 1111, wdata = store_data.
- Load extension:
  - B/H: sign-extend from bit 7/15 of the selected lane.
  - BU/HU: zero-extend.
  - W: pass-through.
- Latency with ready asserted immediately:
  - store stalls 2 cycles (accept, REQ);
  - load stalls 2 cycles plus the response wait.
- Reset mid-operation: return to IDLE at once and drop dmem_req_valid. A later stray dmem_resp_valid is ignored in IDLE and DONE, and load_valid stays 0.
- Only one outstanding access at a time.

Optional Feature:
LSU_TIMEOUT_EN:
- Defined: a counter clears on WAIT_RESP entry and increments each cycle in WAIT_RESP. When it reaches TIMEOUT_CYCLES without a response:
  - lsu_timeout pulses;
  - load_data = 32'h0000_0000;
  - go to DONE with load_valid=1.
- Undefined: no counter; WAIT_RESP waits indefinitely; lsu_timeout tied 0.

Test Plan:
1. SW, alu_out=0x1000_0004, store_data=0xCAFE_BABE, ready=1 -> accept cycle T: stall=1. T+1: req_valid=1, addr=0x1000_0004, we=1111, wdata=0xCAFE_BABE. T+2: DONE, stall=0, no load_valid.
2. SB, alu_out=0x2000_0001, store_data=0x0000_00A5, ready low for 3 cycles -> req_valid held 4 cycles with payload stable: addr=0x2000_0000, we=0010, wdata=0xA5A5_A5A5. DONE follows the handshake.
3. Byte loads at alu_out=0x3000_0003 with resp_data=0x80AA_BBCC, response 2 cycles after handshake:
   - LB -> load_data=0xFFFF_FF80, load_valid pulse 1 cycle.
   - LBU -> load_data=0x0000_0080.
4. Halfword loads at alu_out=0x3000_0002 with resp_data=0x8001_5678:
   - LH -> 0xFFFF_8001.
   - LHU -> 0x0000_8001.
   - LW at 0x3000_0000 -> 0x8001_5678.
5. Illegal accesses: LW at 0x3000_0002 and SH at 0x3000_0001 -> lsu_fault pulse in the accept cycle, dmem_req_valid never asserted, stall=0.
6. LW accepted, reset asserted for 1 cycle in WAIT_RESP, then resp_valid=1 -> FSM in IDLE, load_valid=0, all outputs 0. With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=64, no response -> lsu_timeout pulse 64 cycles after WAIT_RESP entry, load_valid=1, load_data=0.
